// File: rtl/seq_detect_gen.sv
// Serial pattern detector with tick prescaler, modulo-10 match counter and
// 7-segment readout. History is a shift register gated by a fill counter.
module seq_detect_gen #(
    parameter int unsigned        PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PATTERN  = 4'b0011,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int unsigned        TICK_DIV = 20000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    output logic       y,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       blinkled
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HIST_W = PAT_LEN - 1;
    localparam int unsigned FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [HIST_W-1:0]  hist_q,    hist_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic               y_q,       y_d;
    logic [3:0]         digit_q,   digit_d;
    logic               blink_q,   blink_d;

    logic               tick_c;
    logic [PAT_LEN-1:0] win_c;
    logic               hit_c;

    // A hit needs a full window of genuinely sampled bits, so stale zeros never match.
    always_comb begin
        tick_c = (div_cnt_q == DIV_MAX);
        win_c  = {hist_q, x};
        hit_c  = (fill_q == FILL_MAX) && (win_c == PATTERN);
    end

    always_comb begin
        div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        hist_d    = hist_q;
        fill_d    = fill_q;
        y_d       = y_q;
        digit_d   = digit_q;
        blink_d   = blink_q;

        if (tick_c) begin
            y_d     = hit_c;
            blink_d = ~blink_q;

            if (hit_c && (OVERLAP == 1'b0)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = win_c[PAT_LEN-2:0];
                fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
            end

            if (hit_c) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            y_q       <= 1'b0;
            digit_q   <= 4'd0;
            blink_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            y_q       <= y_d;
            digit_q   <= digit_d;
            blink_q   <= blink_d;
        end
    end

    // Segment order a..g on seg[6]..seg[0]; unused codes show a dash.
    always_comb begin
        case (digit_q)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000001;
        endcase
    end

    assign y        = y_q;
    assign digit    = digit_q;
    assign blinkled = blink_q;

endmodule

// File: tb/tb_seq_detect_gen.sv
// Scoreboard bench for seq_detect_gen: stimulus pushes expected outputs per
// cycle, a monitor pops and compares one clock edge later.
module tb_seq_detect_gen;

    typedef struct packed {
        logic       y;
        logic [3:0] digit;
        logic [6:0] seg;
        logic       blink;
        logic       chk_blink;
    } exp_t;

    logic clk;
    logic rst_n_a, rst_n_b, rst_n_c;
    logic xa, xb, xc;

    logic       ya, yb, yc, yd;
    logic [3:0] da, db, dc, dd;
    logic [6:0] sa, sb, sc, sd;
    logic       ba, bb, bc, bd;

    exp_t qa[$], qb[$], qc[$], qd[$];

    int tests = 0;
    int fails = 0;

    seq_detect_gen #(.PAT_LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .TICK_DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n_a), .x(xa), .y(ya), .digit(da), .seg(sa), .blinkled(ba));

    seq_detect_gen #(.PAT_LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .TICK_DIV(5)) u_b (
        .clk(clk), .rst_n(rst_n_b), .x(xb), .y(yb), .digit(db), .seg(sb), .blinkled(bb));

    seq_detect_gen #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .TICK_DIV(1)) u_c (
        .clk(clk), .rst_n(rst_n_c), .x(xc), .y(yc), .digit(dc), .seg(sc), .blinkled(bc));

    seq_detect_gen #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b0), .TICK_DIV(1)) u_d (
        .clk(clk), .rst_n(rst_n_c), .x(xc), .y(yd), .digit(dd), .seg(sd), .blinkled(bd));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic exp_t mk(input logic ey, input int ed, input logic cb, input logic eb);
        exp_t e;
        e.y         = ey;
        e.digit     = 4'(ed);
        e.seg       = seg_of(ed);
        e.blink     = eb;
        e.chk_blink = cb;
        return e;
    endfunction

    task automatic check(input string name, input exp_t e, input logic y,
                         input logic [3:0] d, input logic [6:0] s, input logic b);
        tests++;
        if (y !== e.y || d !== e.digit || s !== e.seg || (e.chk_blink && b !== e.blink)) begin
            fails++;
            $display("FAIL %s @%0t: got y=%b digit=%0d seg=%b blink=%b, expected y=%b digit=%0d seg=%b blink=%b",
                     name, $time, y, d, s, b, e.y, e.digit, e.seg, e.blink);
        end
    endtask

    // Monitor: compare whatever was queued for the edge that just passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin e = qa.pop_front(); check("dut_a", e, ya, da, sa, ba); end
            if (qb.size() > 0) begin e = qb.pop_front(); check("dut_b", e, yb, db, sb, bb); end
            if (qc.size() > 0) begin e = qc.pop_front(); check("dut_c_ovl", e, yc, dc, sc, bc); end
            if (qd.size() > 0) begin e = qd.pop_front(); check("dut_d_noovl", e, yd, dd, sd, bd); end
        end
    end

    task automatic feed_a(input logic xv, input logic ey, input int ed);
        xa = xv;
        qa.push_back(mk(ey, ed, 1'b0, 1'b0));
        @(negedge clk);
    endtask

    task automatic feed_cd(input logic xv, input logic eyc, input int edc,
                           input logic eyd, input int edd);
        xc = xv;
        qc.push_back(mk(eyc, edc, 1'b0, 1'b0));
        qd.push_back(mk(eyd, edd, 1'b0, 1'b0));
        @(negedge clk);
    endtask

    initial begin
        int   bseq[5];
        logic ycv[8], ydv[8];
        int   dcv[8], ddv[8];
        int   t;
        bseq = '{0, 0, 1, 1, 1};
        ycv  = '{0, 0, 0, 1, 0, 1, 0, 1};
        dcv  = '{0, 0, 0, 1, 1, 2, 2, 3};
        ydv  = '{0, 0, 0, 1, 0, 0, 0, 1};
        ddv  = '{0, 0, 0, 1, 1, 1, 1, 2};

        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        xa = 1'b0; xb = 1'b0; xc = 1'b0;

        // Reset held with x toggling: all outputs stay at reset values.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            xa = ~xa; xb = ~xb; xc = ~xc;
            qa.push_back(mk(1'b0, 0, 1'b1, 1'b0));
            qb.push_back(mk(1'b0, 0, 1'b1, 1'b0));
            qc.push_back(mk(1'b0, 0, 1'b1, 1'b0));
            qd.push_back(mk(1'b0, 0, 1'b1, 1'b0));
            @(negedge clk);
        end

        // TICK_DIV=5: heartbeat cadence and glitch immunity between ticks.
        rst_n_b = 1'b1;
        xb = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            if (c % 5 == 0) xb = bseq[c/5 - 1][0];
            else            xb = ~xb;
            t = c / 5;
            qb.push_back(mk((c >= 20 && c < 25), (c >= 20) ? 1 : 0, 1'b1, t[0]));
            @(negedge clk);
        end

        // Basic 0011 match, then a trailing 1 clears y.
        rst_n_a = 1'b1;
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b1, 1'b0, 0);
        feed_a(1'b1, 1'b1, 1);
        feed_a(1'b1, 1'b0, 1);

        // Ten back-to-back matches walk digit through 1..9 and wrap to 0.
        rst_n_a = 1'b0;
        feed_a(1'b0, 1'b0, 0);
        rst_n_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            feed_a(1'b0, 1'b0, (k - 1) % 10);
            feed_a(1'b0, 1'b0, (k - 1) % 10);
            feed_a(1'b1, 1'b0, (k - 1) % 10);
            feed_a(1'b1, 1'b1, k % 10);
        end

        // Asynchronous reset between edges after 0,0,1 drops all history.
        rst_n_a = 1'b0;
        feed_a(1'b0, 1'b0, 0);
        rst_n_a = 1'b1;
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b1, 1'b0, 0);
        #2 rst_n_a = 1'b0;
        #1 check("async_reset", mk(1'b0, 0, 1'b1, 1'b0), ya, da, sa, ba);
        #1 rst_n_a = 1'b1;
        feed_a(1'b1, 1'b0, 0);
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b1, 1'b0, 0);
        feed_a(1'b1, 1'b0, 0);
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b0, 1'b0, 0);
        feed_a(1'b1, 1'b0, 0);
        feed_a(1'b1, 1'b1, 1);

        // 0101 stream into overlapping and non-overlapping detectors.
        rst_n_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            feed_cd(logic'(i % 2), ycv[i], dcv[i], ydv[i], ddv[i]);
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (qa.size() + qb.size() + qc.size() + qd.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     qa.size() + qb.size() + qc.size() + qd.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_gen.md
# seq_detect_gen

Parametrised serial pattern detector with a built-in tick prescaler, a decimal match counter and a 7-segment readout. It generalises the fixed 0011 detector: pattern, pattern length, overlap mode and sample rate are all parameters, and state is held in a shift register rather than hand-derived next-state equations. It sits between a slow board input (switch or button `x`) and the board's 7-segment display and heartbeat LED, clocked from the fabric system clock.

## Interface
- `PAT_LEN`, 4: pattern length in bits, 2..16.
- `PATTERN`, 4'b0011: target sequence, `PAT_LEN` bits wide; MSB is the oldest bit, LSB is the newest.
- `OVERLAP`, 1: 1 means overlapping matches are allowed; 0 means history is cleared after each match.
- `TICK_DIV`, 20000000: clock cycles per sample tick, ≥1.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock; every flop is clocked on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `x` in 1: serial data bit. Sampled only on tick edges.
- `y` out 1: match flag, active-high, registered, held for one tick period.
- `digit` out 4: match count modulo 10, registered.
- `seg` out 7: segment drive for `digit`, active-high. Bit order is `seg[6]`=a through `seg[0]`=g.
- `blinkled` out 1: heartbeat; toggles on every tick.

## Operation
- Prescaler: `div_cnt`, width `max(1,$clog2(TICK_DIV))`.
  - Counts 0..`TICK_DIV`-1, then wraps to 0.
  - `tick` = (`div_cnt` == `TICK_DIV`-1), combinational.
  - With `TICK_DIV`=1, `tick` is high every cycle.
- History: `hist`, a `PAT_LEN`-1 bit shift register. `fill` is a saturating counter, 0..`PAT_LEN`-1.
- Window: `win` = {`hist`, `x`}. `hit` = (`fill` == `PAT_LEN`-1) && (`win` == `PATTERN`).
- On a tick edge:
  - `y` <= `hit`.
  - If `hit` and `OVERLAP`=0: `hist` <= 0 and `fill` <= 0.
  - Otherwise: `hist` <= `win[PAT_LEN-2:0]` and `fill` <= min(`fill`+1, `PAT_LEN`-1).
  - If `hit`: `digit` <= (`digit`==9) ? 0 : `digit`+1.
  - `blinkled` <= ~`blinkled`.
- On a non-tick edge, all registers except `div_cnt` hold.
- `seg` is a combinational decode of `digit`:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 never occur; decode them to 0000001 ("-").
- A match requires `PAT_LEN` bits collected since reset, or since the last match when `OVERLAP`=0. Stale zeros in `hist` never produce a false match, even when `PATTERN` has leading zeros.

## Timing
- Reset values, applied immediately on `rst_n` low:
  - `div_cnt`=0, `hist`=0, `fill`=0
  - `y`=0, `digit`=0, `seg`=1111110, `blinkled`=0
- First tick: `TICK_DIV` cycles after `rst_n` deasserts, on the edge where `div_cnt` reaches `TICK_DIV`-1.
- Latency: the `x` sampled on a tick edge is reflected in `y`, `digit` and `seg` after that same edge. That is 0 ticks of latency and 1 clock of register delay.
- `y` stays stable for exactly `TICK_DIV` cycles, from one tick edge to the next.
- With `TICK_DIV`=1, `y` can be high on consecutive cycles (overlap mode).
- `x` changes between ticks are ignored. `x` has no synchroniser in this block; asynchronous sources are synchronised upstream.
- Reset mid-tick discards the partial prescaler count and all history.
- Simultaneous events:
  - A match on the tick where `digit`=9 wraps `digit` to 0 and sets `y`=1.
  - A match with `OVERLAP`=0 clears `fill`, so the earliest next match is `PAT_LEN` ticks later.

## Test plan
1. **Reset.** Hold `rst_n`=0 for 3 cycles with `x` toggling.
   - Required: `y`=0, `digit`=0, `seg`=1111110, `blinkled`=0 throughout.
   - After release with `TICK_DIV`=5: `blinkled` toggles first on cycle 5, then every 5 cycles.
2. **Basic match.** Defaults with `TICK_DIV`=1; feed `x`=0,0,1,1.
   - Required: `y`=1 only after the 4th tick, `digit`=1, `seg`=0110000.
   - Then feed 1: `y`=0.
3. **Overlap modes.** `PATTERN`=4'b0101, `TICK_DIV`=1; feed 0,1,0,1,0,1,0,1.
   - `OVERLAP`=1: `y` high after ticks 4, 6 and 8; `digit`=3.
   - `OVERLAP`=0: `y` high after ticks 4 and 8 only; `digit`=2.
4. **Digit wrap.** Ten back-to-back 0011 matches.
   - Required: `digit` steps 1..9, then 0, with `seg` matching each decode.
   - On the 10th match: `y`=1 and `seg`=1111110.
5. **Prescaler gating.** `TICK_DIV`=5; change `x` only on non-tick cycles, then present 0,0,1,1 aligned to ticks.
   - Required: glitches cause no state change; `y` rises exactly at the 4th tick and lasts 5 cycles.
6. **Reset mid-sequence.** Feed 0,0,1, pulse `rst_n` low asynchronously between edges, then feed 1.
   - Required: no match; outputs return to reset values at once; `fill` restarts from 0.
